// File: rtl/alu_seq_ctrl.sv
// Sequenced 20-bit ALU controller: IDLE -> EXEC (or ROT) -> RESP with a valid/ready request and response.
// Optional macro ALU_SEQ_ROT_MULTI_EN builds the ROT state for multi-bit rotates; otherwise rotates are 1 bit.
module alu_seq_ctrl #(
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [3:0]        req_shamt,
  input  logic              flag_clr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_sign,
  output logic              rsp_carry,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
`ifdef ALU_SEQ_ROT_MULTI_EN
    S_ROT  = 2'd2,
`endif
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOT = 4'd0, OP_AND = 4'd1, OP_OR = 4'd2, OP_XOR = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4, OP_SHR = 4'd5, OP_ROTL = 4'd6, OP_ROTR = 4'd7;
  localparam logic [3:0] OP_INC = 4'd8, OP_DEC = 4'd9, OP_ADD = 4'd10, OP_ADDC = 4'd11;
  localparam logic [3:0] OP_SUB = 4'd12, OP_EQ = 4'd13, OP_GT = 4'd14, OP_LT = 4'd15;
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t              state, state_d;
  logic [3:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [3:0]          shamt_q;
  logic                carry_q;
  logic                ready_en;
  logic [DATA_W-1:0]   result_q;
  logic                zero_q, sign_q;
  logic                accept;
  logic                rot_multi;
  logic [DATA_W-1:0]   rot1;
  logic [DATA_W-1:0]   alu_res;
  logic [DATA_W:0]     sum;
  logic                alu_carry, alu_zero, alu_sign, cmp_op;
`ifdef ALU_SEQ_ROT_MULTI_EN
  logic [3:0]          rot_cnt;
`endif

  assign req_ready  = ready_en && (state == S_IDLE);
  assign accept     = req_valid && req_ready;
  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);
  assign dbg_state  = state;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_sign   = sign_q;
  assign rsp_carry  = carry_q;

`ifdef ALU_SEQ_ROT_MULTI_EN
  assign rot_multi = ((req_op == OP_ROTL) || (req_op == OP_ROTR)) && (req_shamt > 4'd1);
`else
  assign rot_multi = 1'b0;
`endif

  // Single-bit rotate of the working register, shared by EXEC and every ROT step.
  assign rot1 = (op_q == OP_ROTL) ? {a_q[DATA_W-2:0], a_q[DATA_W-1]} : {a_q[0], a_q[DATA_W-1:1]};

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: if (accept) state_d = rot_multi ? state_t'(2'd2) : S_EXEC;
      S_EXEC: state_d = S_RESP;
`ifdef ALU_SEQ_ROT_MULTI_EN
      S_ROT:  if (rot_cnt == 4'd1) state_d = S_RESP;
`endif
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_res   = '0;
    alu_carry = carry_q;
    sum       = '0;
    cmp_op    = 1'b0;
    case (op_q)
      OP_NOT:  alu_res = ~a_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL:  alu_res = a_q << shamt_q;
      OP_SHR:  alu_res = a_q >> shamt_q;
`ifdef ALU_SEQ_ROT_MULTI_EN
      OP_ROTL, OP_ROTR: alu_res = (shamt_q == 4'd0) ? a_q : rot1;
`else
      OP_ROTL, OP_ROTR: alu_res = rot1;
`endif
      OP_INC: begin
        alu_res   = a_q + ONE;
        alu_carry = (a_q == '1);
      end
      OP_DEC: begin
        alu_res   = a_q - ONE;
        alu_carry = (a_q == '0);
      end
      OP_ADD, OP_ADDC: begin
        sum = {1'b0, a_q} + {1'b0, b_q}
            + {{DATA_W{1'b0}}, (op_q == OP_ADDC) ? carry_q : 1'b0};
        alu_res   = sum[DATA_W-1:0];
        alu_carry = sum[DATA_W];
      end
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
      OP_EQ: begin alu_res = {{(DATA_W-1){1'b0}}, a_q == b_q}; cmp_op = 1'b1; end
      OP_GT: begin alu_res = {{(DATA_W-1){1'b0}}, a_q > b_q};  cmp_op = 1'b1; end
      OP_LT: begin alu_res = {{(DATA_W-1){1'b0}}, a_q < b_q};  cmp_op = 1'b1; end
      default: alu_res = '0;
    endcase
    // Compare ops report equality/less-than in the flags instead of the result bits.
    alu_zero = cmp_op ? (a_q == b_q) : (alu_res == '0);
    alu_sign = cmp_op ? (a_q < b_q)  : alu_res[DATA_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ready_en <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shamt_q  <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
`ifdef ALU_SEQ_ROT_MULTI_EN
      rot_cnt  <= '0;
`endif
    end else begin
      state    <= state_d;
      ready_en <= 1'b1;
      if (accept) begin
        op_q    <= req_op;
        a_q     <= req_a;
        b_q     <= req_b;
        shamt_q <= req_shamt;
`ifdef ALU_SEQ_ROT_MULTI_EN
        rot_cnt <= req_shamt;
`endif
      end
      if (flag_clr) carry_q <= 1'b0;
      else if (state == S_EXEC) carry_q <= alu_carry;
      if (state == S_EXEC) begin
        result_q <= alu_res;
        zero_q   <= alu_zero;
        sign_q   <= alu_sign;
      end
`ifdef ALU_SEQ_ROT_MULTI_EN
      // ROT reuses a_q as the working register; the last step also publishes the result.
      if (state == S_ROT) begin
        a_q     <= rot1;
        rot_cnt <= rot_cnt - 4'd1;
        if (rot_cnt == 4'd1) begin
          result_q <= rot1;
          zero_q   <= (rot1 == '0);
          sign_q   <= rot1[DATA_W-1];
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: scoreboard of expected {carry,sign,zero,result} plus latency/handshake checks.
// Honors ALU_SEQ_ROT_MULTI_EN the same way the design does.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [19:0] req_a = '0;
  logic [19:0] req_b = '0;
  logic [3:0]  req_shamt = '0;
  logic        flag_clr = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [19:0] rsp_result;
  logic        rsp_zero, rsp_sign, rsp_carry;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [22:0] exp_q[$];
  logic        m_carry = 1'b0;
  int          assertions = 0;
  int          failures = 0;

  alu_seq_ctrl #(.DATA_W(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .flag_clr(flag_clr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_carry(rsp_carry),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model; updates m_carry the way the stored carry should evolve.
  function automatic logic [22:0] model_op(input logic [3:0] op, input logic [19:0] a,
                                           input logic [19:0] b, input logic [3:0] sh);
    logic [20:0] w;
    logic [19:0] r;
    logic        c, z, s;
    int          k;
    c = m_carry;
    r = '0;
    case (op)
      4'd0: r = ~a;
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = a << sh;
      4'd5: r = a >> sh;
      4'd6, 4'd7: begin
`ifdef ALU_SEQ_ROT_MULTI_EN
        k = int'(sh) % 20;
`else
        k = 1;
`endif
        for (int i = 0; i < 20; i++) begin
          if (op == 4'd6) r[(i + k) % 20] = a[i];
          else            r[i] = a[(i + k) % 20];
        end
      end
      4'd8:  begin w = {1'b0, a} + 21'd1; r = w[19:0]; c = (a == 20'hFFFFF); end
      4'd9:  begin r = a - 20'd1; c = (a == 20'd0); end
      4'd10: begin w = {1'b0, a} + {1'b0, b}; r = w[19:0]; c = w[20]; end
      4'd11: begin w = {1'b0, a} + {1'b0, b} + {20'd0, m_carry}; r = w[19:0]; c = w[20]; end
      4'd12: begin r = a - b; c = (a < b); end
      4'd13: r = {19'd0, a == b};
      4'd14: r = {19'd0, a > b};
      default: r = {19'd0, a < b};
    endcase
    if (op >= 4'd13) begin z = (a == b); s = (a < b); end
    else begin z = (r == 20'd0); s = r[19]; end
    m_carry = c;
    return {c, s, z, r};
  endfunction

  task automatic resync();
    rst_n = 1'b0;
    req_valid = 1'b0;
    flag_clr = 1'b0;
    rsp_ready = 1'b0;
    m_carry = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Driver + scoreboard for one operation; hold = cycles to keep rsp_ready low in RESP.
  task automatic run_op(input logic [3:0] op, input logic [19:0] a, input logic [19:0] b,
                        input logic [3:0] sh, input logic clr, input int hold);
    logic [22:0] exp;
    int lat, exp_lat, n;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_shamt = sh;
    req_valid = 1'b1; flag_clr = clr;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    assertions++;
    if (!req_ready) begin
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
      failures++;
      resync();
      return;
    end
    if (clr) m_carry = 1'b0;
    exp_q.push_back(model_op(op, a, b, sh));
`ifdef ALU_SEQ_ROT_MULTI_EN
    exp_lat = ((op == 4'd6 || op == 4'd7) && sh > 4'd1) ? int'(sh) + 1 : 2;
`else
    exp_lat = 2;
`endif
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flag_clr = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
    assertions++;
    if (!rsp_valid) begin
      $display("FAIL rsp_timeout op=%0d: rsp_valid=0 required 1", op);
      failures++;
      resync();
      return;
    end
    // lat counts edges until rsp_valid is registered; it is seen at the following edge.
    assertions++;
    if (lat + 1 !== exp_lat) begin
      $display("FAIL latency op=%0d sh=%0d: got %0d edges required %0d", op, sh, lat + 1, exp_lat);
      failures++;
    end
    exp = exp_q.pop_front();
    assertions++;
    if ({rsp_carry, rsp_sign, rsp_zero, rsp_result} !== exp) begin
      $display("FAIL result op=%0d a=%h b=%h sh=%0d: got c%0b s%0b z%0b %h required c%0b s%0b z%0b %h",
               op, a, b, sh, rsp_carry, rsp_sign, rsp_zero, rsp_result,
               exp[22], exp[21], exp[20], exp[19:0]);
      failures++;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      assertions++;
      if ({rsp_valid, req_ready, rsp_carry, rsp_sign, rsp_zero, rsp_result} !== {2'b10, exp}) begin
        $display("FAIL hold cycle %0d: got v%0b rdy%0b %h required v1 rdy0 %h",
                 i, rsp_valid, req_ready, {rsp_carry, rsp_sign, rsp_zero, rsp_result}, exp);
        failures++;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    assertions++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL resume: got req_ready=%0b rsp_valid=%0b required 1 0", req_ready, rsp_valid);
      failures++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    assertions++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_sign, rsp_carry, busy, req_ready, dbg_state} !== 28'd0) begin
      $display("FAIL reset_values: got v%0b %h z%0b s%0b c%0b busy%0b rdy%0b st%0d required all 0",
               rsp_valid, rsp_result, rsp_zero, rsp_sign, rsp_carry, busy, req_ready, dbg_state);
      failures++;
    end
    rst_n = 1'b1;
    #1;
    assertions++;
    if (req_ready !== 1'b0) begin
      $display("FAIL ready_before_edge: got %0b required 0", req_ready);
      failures++;
    end
    @(posedge clk);
    #1;
    assertions++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL ready_after_edge: got rdy=%0b busy=%0b required 1 0", req_ready, busy);
      failures++;
    end
  endtask

  task automatic test_add_carry();
    run_op(4'd10, 20'hFFFFF, 20'd1, 4'd0, 1'b0, 0);
    run_op(4'd11, 20'd1, 20'd1, 4'd0, 1'b0, 0);
    run_op(4'd11, 20'hFFFFF, 20'd0, 4'd0, 1'b0, 0);
    run_op(4'd8, 20'hFFFFF, 20'd0, 4'd0, 1'b0, 0);
    run_op(4'd9, 20'd0, 20'd0, 4'd0, 1'b0, 0);
    run_op(4'd9, 20'd5, 20'd0, 4'd0, 1'b0, 0);
  endtask

  task automatic test_shift_rotate();
    run_op(4'd6, 20'h80001, 20'd0, 4'd4, 1'b0, 0);
    run_op(4'd7, 20'h80001, 20'd0, 4'd9, 1'b0, 0);
    run_op(4'd6, 20'h12345, 20'd0, 4'd0, 1'b0, 0);
    run_op(4'd7, 20'h12345, 20'd0, 4'd1, 1'b0, 0);
    run_op(4'd6, 20'hC0003, 20'd0, 4'd15, 1'b0, 0);
    run_op(4'd4, 20'h80001, 20'd0, 4'd0, 1'b0, 0);
    run_op(4'd4, 20'h0F0F1, 20'd0, 4'd15, 1'b0, 0);
    run_op(4'd5, 20'h80000, 20'd0, 4'd7, 1'b0, 0);
  endtask

  task automatic test_sub_compare();
    run_op(4'd12, 20'd5, 20'd7, 4'd0, 1'b0, 0);
    run_op(4'd15, 20'd5, 20'd7, 4'd0, 1'b0, 0);
    run_op(4'd13, 20'd9, 20'd9, 4'd0, 1'b0, 0);
    run_op(4'd14, 20'd9, 20'd3, 4'd0, 1'b0, 0);
    run_op(4'd0, 20'h0000F, 20'd0, 4'd0, 1'b0, 0);
    run_op(4'd3, 20'hAAAAA, 20'hAAAAA, 4'd0, 1'b0, 0);
  endtask

  task automatic test_hold();
    run_op(4'd10, 20'h7FFFF, 20'd1, 4'd0, 1'b0, 10);
  endtask

  task automatic test_flag_clr();
    run_op(4'd8, 20'hFFFFF, 20'd0, 4'd0, 1'b0, 0);
    run_op(4'd11, 20'd0, 20'd0, 4'd0, 1'b1, 0);
  endtask

  task automatic test_random();
    logic [19:0] a, b;
    for (int i = 0; i < 40; i++) begin
      a = 20'($urandom());
      b = ($urandom_range(0, 3) == 0) ? a : 20'($urandom());
      if ($urandom_range(0, 5) == 0) a = 20'hFFFFF;
      run_op(4'($urandom_range(0, 15)), a, b, 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid_rot();
    int seen;
    run_op(4'd10, 20'hFFFFF, 20'd1, 4'd0, 1'b0, 0);
    @(negedge clk);
    req_op = 4'd6; req_a = 20'h12345; req_b = '0; req_shamt = 4'd9; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    m_carry = 1'b0;
    #1;
    assertions++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_sign, rsp_carry, busy, req_ready, dbg_state} !== 28'd0) begin
      $display("FAIL reset_mid_op: got v%0b %h z%0b s%0b c%0b busy%0b rdy%0b st%0d required all 0",
               rsp_valid, rsp_result, rsp_zero, rsp_sign, rsp_carry, busy, req_ready, dbg_state);
      failures++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    assertions++;
    if (req_ready !== 1'b1) begin
      $display("FAIL ready_after_mid_reset: got %0b required 1", req_ready);
      failures++;
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    assertions++;
    if (seen != 0) begin
      $display("FAIL discarded_op: rsp_valid high %0d cycles required 0", seen);
      failures++;
    end
    run_op(4'd11, 20'd1, 20'd1, 4'd0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_shift_rotate();
    test_sub_compare();
    test_hold();
    test_flag_clr();
    test_random();
    test_reset_mid_rot();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
